// File: rtl/pe_array_ctrl.sv
// Job sequencer for a ROWS x COLS pe_m array: mode select, operand feed strobes/index, drain wait, done pulse.
// Optional macro PE_ARRAY_CTRL_PERF_EN adds the perf_cyc_o busy-cycle counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_i; gemm_uno_o keeps the last job's mode
// S_LOAD  | one cycle after accept; reject klen=0, else prime the feed
// S_FEED  | issue klen operand beats (gemm beats gated by feed_rdy_i)
// S_DRAIN | wait for the array pipeline to empty
// S_DONE  | one-cycle done_o (with err_o on reject)
module pe_array_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int CNT_BW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_BW-1:0] klen_i,
    input  logic              abort_i,
    input  logic              feed_rdy_i,
    output logic              busy_o,
    output logic [1:0]        gemm_uno_o,
    output logic              feed_en_o,
    output logic [CNT_BW-1:0] feed_idx_o,
    output logic              done_o,
    output logic              err_o
`ifdef PE_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cyc_o
`endif
);

    localparam int DRN_BW = $clog2(ROWS + COLS);
    // DRAIN lasts (load value + 1) cycles because the count runs down to zero inclusive
    localparam logic [DRN_BW-1:0] DRN_GEMM = DRN_BW'(ROWS + COLS - 1);
    localparam logic [DRN_BW-1:0] DRN_UNO  = DRN_BW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_BW-1:0]   klen_q, klen_d;
    logic [DRN_BW-1:0]   drain_q, drain_d;
    logic                busy_d;
    logic [1:0]          gemm_uno_d;
    logic                feed_en_d;
    logic [CNT_BW-1:0]   idx_d;
    logic                done_d;
    logic                err_d;
    logic                is_gemm;
    logic                last_beat;

    assign is_gemm   = (mode_q == 2'b00);
    assign last_beat = feed_en_o && (feed_idx_o == (klen_q - CNT_BW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            klen_q     <= '0;
            drain_q    <= '0;
            busy_o     <= 1'b0;
            gemm_uno_o <= 2'b00;
            feed_en_o  <= 1'b0;
            feed_idx_o <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            klen_q     <= klen_d;
            drain_q    <= drain_d;
            busy_o     <= busy_d;
            gemm_uno_o <= gemm_uno_d;
            feed_en_o  <= feed_en_d;
            feed_idx_o <= idx_d;
            done_o     <= done_d;
            err_o      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        klen_d     = klen_q;
        drain_d    = drain_q;
        busy_d     = busy_o;
        gemm_uno_d = gemm_uno_o;
        feed_en_d  = 1'b0;
        idx_d      = feed_idx_o;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start_i) begin
                    state_d    = S_LOAD;
                    busy_d     = 1'b1;
                    mode_d     = mode_i;
                    klen_d     = klen_i;
                    gemm_uno_d = mode_i;
                end
            end
            S_LOAD: begin
                idx_d = '0;
                if (klen_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d   = S_FEED;
                    feed_en_d = is_gemm ? feed_rdy_i : 1'b1;
                end
            end
            S_FEED: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                    drain_d = is_gemm ? DRN_GEMM : DRN_UNO;
                end else begin
                    // idx shows the next beat to issue, so it holds across gemm bubbles
                    idx_d     = feed_idx_o + CNT_BW'(feed_en_o);
                    feed_en_d = is_gemm ? feed_rdy_i : 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DRN_BW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            feed_en_d = 1'b0;
            idx_d     = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            drain_d   = '0;
        end
    end

`ifdef PE_ARRAY_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cyc_o <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            perf_cyc_o <= '0;
        end else if (busy_o && (perf_cyc_o != 32'hFFFF_FFFF)) begin
            perf_cyc_o <= perf_cyc_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: stimulus queues expected beats/done events, a negedge monitor checks them.
module tb_pe_array_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [1:0] mode_i;
    logic [7:0] klen_i;
    logic       abort_i;
    logic       feed_rdy_i;
    logic       busy_o;
    logic [1:0] gemm_uno_o;
    logic       feed_en_o;
    logic [7:0] feed_idx_o;
    logic       done_o;
    logic       err_o;
`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_cyc_o;
`endif

    pe_array_ctrl #(.ROWS(4), .COLS(4), .CNT_BW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .klen_i     (klen_i),
        .abort_i    (abort_i),
        .feed_rdy_i (feed_rdy_i),
        .busy_o     (busy_o),
        .gemm_uno_o (gemm_uno_o),
        .feed_en_o  (feed_en_o),
        .feed_idx_o (feed_idx_o),
        .done_o     (done_o),
        .err_o      (err_o)
`ifdef PE_ARRAY_CTRL_PERF_EN
        ,
        .perf_cyc_o (perf_cyc_o)
`endif
    );

    typedef struct packed {
        logic        is_done;
        logic        err;
        logic [7:0]  idx;
        logic [1:0]  mode;
        logic [31:0] lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_job(input logic [1:0] m, input int k, input int lat, input logic err);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e = '{is_done: 1'b0, err: 1'b0, idx: 8'(i), mode: m, lat: 32'd0};
            exp_q.push_back(e);
        end
        e = '{is_done: 1'b1, err: err, idx: 8'd0, mode: m, lat: 32'(lat)};
        exp_q.push_back(e);
    endtask

    task automatic push_beat(input logic [1:0] m, input int i);
        exp_t e;
        e = '{is_done: 1'b0, err: 1'b0, idx: 8'(i), mode: m, lat: 32'd0};
        exp_q.push_back(e);
    endtask

    task automatic accept(input logic [1:0] m, input logic [7:0] k);
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = m;
        klen_i  = k;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // monitor: every beat or done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (feed_en_o || done_o)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: feed_en=%0b done=%0b idx=%0d, expected no output",
                         feed_en_o, done_o, feed_idx_o);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done) begin
                    chk("done_pulse", {31'd0, done_o}, 32'd1);
                    chk("done_err", {31'd0, err_o}, {31'd0, e.err});
                    chk("done_latency", 32'(cyc - acc_cyc + 1), e.lat);
                    chk("done_no_feed", {31'd0, feed_en_o}, 32'd0);
                end else begin
                    chk("beat_en", {31'd0, feed_en_o}, 32'd1);
                    chk("beat_idx", {24'd0, feed_idx_o}, {24'd0, e.idx});
                    chk("beat_mode", {30'd0, gemm_uno_o}, {30'd0, e.mode});
                    chk("beat_no_done", {31'd0, done_o}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        mode_i     = 2'b00;
        klen_i     = 8'd0;
        abort_i    = 1'b0;
        feed_rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mode", {30'd0, gemm_uno_o}, 32'd0);
        chk("rst_feed_en", {31'd0, feed_en_o}, 32'd0);
        chk("rst_idx", {24'd0, feed_idx_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
`ifdef PE_ARRAY_CTRL_PERF_EN
        chk("rst_perf", perf_cyc_o, 32'd0);
`endif

        // gemm klen=8, no stalls: 1 + 8 + 8 + 1
        push_job(2'b00, 8, 18, 1'b0);
        accept(2'b00, 8'd8);
        wait_idle("gemm8");
`ifdef PE_ARRAY_CTRL_PERF_EN
        chk("perf_after_done", perf_cyc_o, 32'd18);
        repeat (3) @(negedge clk);
        chk("perf_hold", perf_cyc_o, 32'd18);
`endif

        // gemm klen=4 with a 3-cycle bubble after beat 1
        push_job(2'b00, 4, 17, 1'b0);
        accept(2'b00, 8'd4);
        @(negedge clk);
`ifdef PE_ARRAY_CTRL_PERF_EN
        chk("perf_clear_on_accept", perf_cyc_o, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        feed_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_en_low", {31'd0, feed_en_o}, 32'd0);
            chk("stall_idx_hold", {24'd0, feed_idx_o}, 32'd2);
        end
        feed_rdy_i = 1'b1;
        wait_idle("gemm_stall");

        // exp klen=5 ignores feed_rdy_i: 1 + 5 + 4 + 1
        feed_rdy_i = 1'b0;
        push_job(2'b10, 5, 11, 1'b0);
        accept(2'b10, 8'd5);
        @(negedge clk);
        chk("exp_mode_in_load", {30'd0, gemm_uno_o}, 32'd2);
        wait_idle("exp5");
        feed_rdy_i = 1'b1;
        chk("mode_held_idle", {30'd0, gemm_uno_o}, 32'd2);
        chk("idle_not_busy", {31'd0, busy_o}, 32'd0);

        // klen=0 rejected: done+err two cycles after accept, no beats
        push_job(2'b01, 0, 2, 1'b1);
        accept(2'b01, 8'd0);
        wait_idle("reject");

        // div klen=6 aborted in third FEED cycle; start while busy ignored
        push_beat(2'b01, 0);
        push_beat(2'b01, 1);
        push_beat(2'b01, 2);
        accept(2'b01, 8'd6);
        @(negedge clk);
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = 2'b00;
        klen_i  = 8'd9;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_feed_en", {31'd0, feed_en_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_mode_kept", {30'd0, gemm_uno_o}, 32'd1);
        wait_idle("abort");

        // new job accepted normally after abort: 1 + 2 + 8 + 1
        push_job(2'b00, 2, 12, 1'b0);
        accept(2'b00, 8'd2);
        wait_idle("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
